// File: rtl/imem_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : imem_fetch_unit                                               |
// | Purpose  : Instruction memory between the PC/fetch stage and decode.     |
// |            After reset it zeroes every word in a hardware sweep. It      |
// |            accepts program-load writes and serves byte-addressed fetches |
// |            over a valid/ready handshake with back-pressure. Misaligned   |
// |            and out-of-range fetches return zero data with an error flag. |
// | Ports    : clk        - clock, rising edge                               |
// |            reset      - synchronous, active-low reset                    |
// |            busy       - high while the clear sweep runs                  |
// |            ld_en      - program-load write strobe                        |
// |            ld_addr    - program-load word index                          |
// |            ld_data    - program-load data                                |
// |            req_valid  - fetch request valid                              |
// |            req_ready  - fetch request can be accepted this cycle         |
// |            req_addr   - fetch byte address                               |
// |            resp_valid - fetch response valid                             |
// |            resp_ready - consumer takes the response                      |
// |            resp_data  - fetched instruction word (0 on error)            |
// |            resp_err   - response belongs to a bad address                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module imem_fetch_unit #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 64,
   parameter int ADDR_W = $clog2(DEPTH),
   parameter int PC_W   = 32
) (
   input  logic              clk,
   input  logic              reset,
   output logic              busy,
   input  logic              ld_en,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [PC_W-1:0]   req_addr,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_data,
   output logic              resp_err
);

   // Last word index written by the clear sweep.
   localparam logic [ADDR_W-1:0] c_LAST_IDX   = ADDR_W'(DEPTH - 1);
   // DEPTH in one extra bit so a full-range ld_addr can be compared safely.
   localparam logic [ADDR_W:0]   c_DEPTH_CMP  = (ADDR_W + 1)'(DEPTH);
   // First illegal byte address. One extra bit keeps 4*DEPTH from wrapping
   // when PC_W is small.
   localparam logic [PC_W:0]     c_ADDR_LIMIT = (PC_W + 1)'(4 * DEPTH);

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [ADDR_W-1:0] r_clr_ptr;
   logic [ADDR_W-1:0] w_clr_ptr_nxt;

   logic [DATA_W-1:0] r_mem [DEPTH];

   logic              w_mem_we;
   logic [ADDR_W-1:0] w_mem_waddr;
   logic [DATA_W-1:0] w_mem_wdata;

   logic              w_req_ready;
   logic              w_accept;
   logic              w_ld_in_range;
   logic              w_bad;
   logic [ADDR_W-1:0] w_rd_idx;

   logic              r_resp_valid;
   logic [DATA_W-1:0] r_resp_data;
   logic              r_resp_err;

   assign w_ld_in_range = ({1'b0, ld_addr} < c_DEPTH_CMP);
   assign w_rd_idx      = req_addr[ADDR_W+1:2];
   // The full PC_W-bit address takes part in the range check. Upper address
   // bits must not alias back into the array.
   assign w_bad         = (req_addr[1:0] != 2'b00) ||
                          ({1'b0, req_addr} >= c_ADDR_LIMIT);
   assign w_accept      = req_valid && w_req_ready;

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state   <= ST_CLEAR;
         r_clr_ptr <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_clr_ptr <= w_clr_ptr_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // Next state, memory write port and request handshake
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt   = r_state;
      w_clr_ptr_nxt = r_clr_ptr;
      w_mem_we      = 1'b0;
      w_mem_waddr   = r_clr_ptr;
      w_mem_wdata   = '0;
      w_req_ready   = 1'b0;

      case (r_state)
         ST_CLEAR: begin
            // The sweep owns the write port, so program loads are dropped.
            w_mem_we      = 1'b1;
            w_mem_waddr   = r_clr_ptr;
            w_clr_ptr_nxt = r_clr_ptr + 1'b1;
            if (r_clr_ptr == c_LAST_IDX) begin
               w_state_nxt   = ST_READY;
               w_clr_ptr_nxt = '0;
            end
         end
         ST_READY: begin
            w_mem_we    = ld_en && w_ld_in_range;
            w_mem_waddr = ld_addr;
            w_mem_wdata = ld_data;
            // Load wins over fetch. This keeps a read and a write from ever
            // landing in the same cycle.
            w_req_ready = !ld_en && (!r_resp_valid || resp_ready);
         end
         default: begin
            w_state_nxt = ST_CLEAR;
         end
      endcase

      // No write and no acceptance while reset is asserted.
      if (!reset) begin
         w_mem_we    = 1'b0;
         w_req_ready = 1'b0;
      end
   end

   // ------------------------------------------------------------------------
   // Storage (not reset; the sweep clears it)
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         r_mem[w_mem_waddr] <= w_mem_wdata;
      end
   end

   // ------------------------------------------------------------------------
   // Response register: data and error hold until a new request is accepted
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_resp_valid <= 1'b0;
         r_resp_data  <= '0;
         r_resp_err   <= 1'b0;
      end else if (w_accept) begin
         r_resp_valid <= 1'b1;
         r_resp_data  <= w_bad ? '0 : r_mem[w_rd_idx];
         r_resp_err   <= w_bad;
      end else if (resp_ready) begin
         r_resp_valid <= 1'b0;
      end
   end

   assign busy       = (r_state == ST_CLEAR);
   assign req_ready  = w_req_ready;
   assign resp_valid = r_resp_valid;
   assign resp_data  = r_resp_data;
   assign resp_err   = r_resp_err;

endmodule
`default_nettype wire

// File: doc/imem_fetch_unit.md
# imem_fetch_unit

Parametrised instruction memory for the single-cycle/pipelined CPU. It sits between the PC/fetch stage and the decode stage. It adds four things over a plain word array:
- a hardware clear sweep after reset,
- a program-load write port,
- a byte-addressed fetch interface with a valid/ready request/response handshake and back-pressure,
- misalignment and out-of-range error reporting.

## Interface
- `DATA_W`, default 32: instruction word width in bits.
- `DEPTH`, default 64: number of words; any value ≥ 2, not necessarily a power of two.
- `ADDR_W`, default `$clog2(DEPTH)`: word-index width.
- `PC_W`, default 32: width of the byte address on the fetch port.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `reset`  in  1  reset, synchronous, active-low.
- `busy`  out  1  high while the clear sweep runs.
- `ld_en`  in  1  program-load write strobe.
- `ld_addr`  in  ADDR_W  load word index.
- `ld_data`  in  DATA_W  load data.
- `req_valid`  in  1  fetch request valid.
- `req_ready`  out  1  fetch request accepted this cycle if `req_valid` is also high.
- `req_addr`  in  PC_W  fetch byte address.
- `resp_valid`  out  1  response valid.
- `resp_ready`  in  1  consumer can take the response.
- `resp_data`  out  DATA_W  instruction word.
- `resp_err`  out  1  the response belongs to a bad address.

## Operation
**States:** CLEAR and READY. An internal clear pointer `clr_ptr` has width ADDR_W.

**Reset (sampled low on a rising edge):**
- state ← CLEAR, `clr_ptr` ← 0.
- `busy` ← 1, `resp_valid` ← 0, `resp_data` ← 0, `resp_err` ← 0.
- `req_ready` is 0 while in reset.
- Memory contents are not touched by reset itself.
- Reset mid-operation drops any pending response and restarts the sweep from 0.

**CLEAR:**
- Each cycle, write 0 to `mem[clr_ptr]` and increment `clr_ptr`.
- After writing `DEPTH-1`, go to READY; `busy` falls on that same edge.
- `ld_en` is ignored (the write is dropped). `req_ready` = 0.

**READY, load:**
- When `ld_en` = 1 and `ld_addr` < DEPTH, write `mem[ld_addr]` ← `ld_data`.
- When `ld_addr` ≥ DEPTH, drop the write silently.

**READY, fetch:**
- `req_ready` = !`ld_en` && (!`resp_valid` || `resp_ready`). This is combinational; load has priority over fetch.
- Word index = `req_addr[ADDR_W+1:2]`.
- The address is bad if `req_addr[1:0]` ≠ 0 or `req_addr` ≥ 4·DEPTH. Compare in PC_W bits; no truncation before the compare.
- On acceptance (`req_valid` && `req_ready`):
  - `resp_valid` ← 1 on the next edge.
  - `resp_data` ← `mem[index]`, or 0 if the address is bad.
  - `resp_err` ← bad.
- If no acceptance and `resp_ready` = 1, then `resp_valid` ← 0. `resp_data`/`resp_err` hold their last values.
- While `resp_valid` && !`resp_ready`, `resp_data` and `resp_err` stay stable and no new request is accepted.

**Read/write ordering:** a fetch is never accepted in a cycle where `ld_en` = 1, so there is no same-cycle read/write collision. A load at cycle n is visible to a fetch accepted at cycle n+1.

## Timing
- Clear sweep: exactly DEPTH cycles.
  - With reset released before edge 0, `busy` is 1 through edges 0..DEPTH-1 and 0 after edge DEPTH-1.
  - The first possible request acceptance is the edge after that.
- Fetch latency: 1 cycle, from the accepting edge to `resp_valid` being high.
- Throughput: 1 fetch/cycle while `resp_ready` = 1 and `ld_en` = 0.
- Load write latency: the write completes at the sampling edge.
- Stall: any number of cycles with `resp_ready` = 0 causes no loss and no duplication.

## Test plan
Defaults unless noted: DEPTH=64, DATA_W=32.

1. **Reset and clear:** hold `reset` = 0 for 3 cycles, release, then fetch addresses 0x00, 0x04 and 0xFC. Required:
   - `busy` is high for exactly 64 cycles.
   - `req_ready` stays 0 throughout the sweep.
   - Each response has `resp_data` = 0 and `resp_err` = 0.
2. **Load then back-to-back fetch:** load 0x20000001 at index 0, 0x8C010004 at index 1 and 0xAC020008 at index 63, then fetch 0x00, 0x04 and 0xFC on consecutive cycles with `resp_ready` = 1. Required: three consecutive `resp_valid` cycles carrying those words in order.
3. **Back-pressure:** fetch 0x04, then hold `resp_ready` = 0 for 4 cycles while `req_valid` = 1 with address 0x00. Required:
   - `req_ready` = 0.
   - `resp_data` holds 0x8C010004.
   - After `resp_ready` rises: exactly one response 0x8C010004, then 0x20000001.
4. **Errors:** fetch 0x02, then 0x100, then 0xFFFFFFFC. Required: each response has `resp_err` = 1 and `resp_data` = 0. Then fetch 0x04 and require `resp_err` = 0.
5. **Load priority and dropped writes:**
   - Assert `ld_en` (index 5, value 0x12345678) together with `req_valid`. Required: `req_ready` = 0 in that cycle; the next-cycle fetch of 0x14 returns 0x12345678.
   - With DEPTH=48, a load to index 50 is dropped.
   - A load during CLEAR is dropped: the word still reads 0 afterwards.
6. **Reset mid-stall:** leave a response pending with `resp_ready` = 0, then pulse `reset` = 0. Required: `resp_valid` drops on that edge, `busy` returns to 1, and a full clear follows (previously loaded words read 0).
